// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the dmem_responder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int BE_W  = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// Module      : dmem_array
// Description : Byte-enabled word array with synchronous write and a
//               registered read port, both qualified by the commit strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately left unreset; only committed stores change them.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : Valid/ready data-memory slave with programmable wait states.
//               Optional address checking enabled by DMEM_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_rd_sel;
    logic              r_err;
    logic              w_accept;
    logic              w_commit;
    logic              w_fault;
    logic              w_rsp_done;
    logic [DATA_W-1:0] w_arr_rdata;

    assign req_ready  = (r_state == IDLE) && !reset;
    assign w_accept   = req_valid && req_ready;
    assign w_commit   = (r_state == WAIT) && (r_cnt == '0) && !reset;
    assign w_rsp_done = (r_state == RESP) && rsp_ready;

`ifdef DMEM_ADDR_CHECK_EN
    assign w_fault = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{r_addr[31:ADDR_W+2], r_addr[1:0]};
    assign w_fault       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0)   w_state_nxt = RESP;
            RESP:    if (rsp_ready)     w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    // Loading WAIT_CYCLES (not minus one) puts the commit edge at accept+1+WAIT_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(WAIT_CYCLES);
        end else if ((r_state == WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_commit) begin
            r_rd_sel <= !r_we && !w_fault;
            r_err    <= w_fault;
        end else if (w_rsp_done) begin
            r_rd_sel <= 1'b0;
            r_err    <= 1'b0;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .i_wr_en (w_commit && r_we && !w_fault),
        .i_rd_en (w_commit && !r_we && !w_fault),
        .i_idx   (r_addr[ADDR_W+1:2]),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_arr_rdata)
    );

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rd_sel ? w_arr_rdata : '0;
    assign rsp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench; index 0 = WAIT_CYCLES 2,
//               1 = WAIT_CYCLES 0, 2 = WAIT_CYCLES 7.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(7)) dut_w7 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; lat counts edges from accept to first rsp_valid.
    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata, output logic err);
        int j;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        j = 0;
        while (!req_ready[d] && j < 50) begin
            @(negedge clk);
            j++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = ~wdata;
        req_addr[d]  = ~addr;
        lat = 0;
        while (!rsp_valid[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("rsp_valid_clear", {31'd0, rsp_valid[d]}, 32'd0);
        check("rsp_rdata_clear", rsp_rdata[d], 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          j;

        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0;   req_be[d] = '0;   rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_req_ready", {31'd0, req_ready[d]}, 32'd0);
            check("reset_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[d], 32'd0);
            check("reset_rsp_err",   {31'd0, rsp_err[d]},   32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("post_reset_ready", {31'd0, req_ready[d]}, 32'd1);

        // Basic store/load, WAIT_CYCLES = 2
        xact(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, lat, rd, er);
        check("store_lat", 32'(lat), 32'd3);
        check("store_rdata", rd, 32'd0);
        check("store_err", {31'd0, er}, 32'd0);
        xact(0, 1'b0, 32'h8, 32'h0, 4'h0, lat, rd, er);
        check("load_lat", 32'(lat), 32'd3);
        check("load_rdata", rd, 32'hDEADBEEF);
        check("load_err", {31'd0, er}, 32'd0);

        // Byte enables
        xact(0, 1'b1, 32'h4, 32'h11223344, 4'hF, lat, rd, er);
        xact(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'h5, lat, rd, er);
        xact(0, 1'b0, 32'h4, 32'h0, 4'h0, lat, rd, er);
        check("be_merge", rd, 32'h11BB33DD);
        xact(0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'h0, lat, rd, er);
        check("be0_err", {31'd0, er}, 32'd0);
        xact(0, 1'b0, 32'h4, 32'h0, 4'hF, lat, rd, er);
        check("be0_nochange", rd, 32'h11BB33DD);

        // Backpressure with a concurrent request waiting
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h8; req_be[0] = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h0BADF00D; req_be[0] = 4'hF;
        j = 0;
        while (!rsp_valid[0] && j < 50) begin
            check("bp_wait_req_ready", {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
            j++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
            check("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        check("bp_after_hs_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("bp_after_hs_ready", {31'd0, req_ready[0]}, 32'd1);
        @(negedge clk);
        check("bp_second_accepted", {31'd0, req_ready[0]}, 32'd0);
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("bp_second_lat", 32'(lat), 32'd3);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        check("bp_second_data", rd, 32'h0BADF00D);

        // Reset while a store sits in WAIT
        xact(0, 1'b1, 32'hC, 32'h0, 4'hF, lat, rd, er);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'hC;
        req_wdata[0] = 32'h5A5A5A5A; req_be[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("mid_rst_rsp_err",   {31'd0, rsp_err[0]},   32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", {31'd0, req_ready[0]}, 32'd1);
        xact(0, 1'b0, 32'hC, 32'h0, 4'h0, lat, rd, er);
        check("mid_rst_discard", rd, 32'h0);

`ifdef DMEM_ADDR_CHECK_EN
        xact(0, 1'b1, 32'h6, 32'h12345678, 4'hF, lat, rd, er);
        check("misalign_store_err", {31'd0, er}, 32'd1);
        check("misalign_store_lat", 32'(lat), 32'd3);
        xact(0, 1'b0, 32'h4, 32'h0, 4'h0, lat, rd, er);
        check("misalign_no_write", rd, 32'h11BB33DD);
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, er);
        xact(0, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd, er);
        check("range_load_err", {31'd0, er}, 32'd1);
        check("range_load_rdata", rd, 32'h0);
`else
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, lat, rd, er);
        xact(0, 1'b0, 32'h80, 32'h0, 4'h0, lat, rd, er);
        check("wrap_load_rdata", rd, 32'hCAFEF00D);
        check("wrap_load_err", {31'd0, er}, 32'd0);
        xact(0, 1'b0, 32'h6, 32'h0, 4'h0, lat, rd, er);
        check("low_bits_ignored", rd, 32'h11BB33DD);
`endif

        // WAIT_CYCLES = 0 and 7
        xact(1, 1'b1, 32'h14, 32'h13579BDF, 4'hF, lat, rd, er);
        check("w0_store_lat", 32'(lat), 32'd1);
        xact(1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er);
        check("w0_load_lat", 32'(lat), 32'd1);
        check("w0_load_rdata", rd, 32'h13579BDF);
        xact(2, 1'b1, 32'h1C, 32'h2468ACE0, 4'hF, lat, rd, er);
        check("w7_store_lat", 32'(lat), 32'd8);
        xact(2, 1'b0, 32'h1C, 32'h0, 4'h0, lat, rd, er);
        check("w7_load_lat", 32'(lat), 32'd8);
        check("w7_load_rdata", rd, 32'h2468ACE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
